// File: rtl/cp0_regs.sv
// CP0 register file (Status, Cause, EPC, Count, Compare, BadVAddr) with M-stage exception/interrupt decision.
// Reads and take/flush outputs are combinational; all register effects land on the next posedge.
module cp0_regs (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic [5:0]  hw_int,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_req,
    output logic        int_req,
    output logic        exc_flush,
    output logic [31:0] epc
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] badvaddr_q;
    logic        tick;

    logic [7:0]  cause_ip;
    logic        int_pend;
    logic        exc_take;
    logic        eret_take;
    logic        wr_en;
    logic [4:0]  taken_code;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    assign cause_ip   = {cause_ip_hw, cause_ip_sw};
    assign int_pend   = (|(cause_ip & status_im)) & status_ie & ~status_exl;
    assign exc_take   = commit_valid & (int_pend | exc_req);
    assign eret_take  = commit_valid & eret_req & ~exc_take;
    // A taken interrupt/exception squashes the M-stage mtc0.
    assign wr_en      = mtc0_we & ~exc_take;
    assign taken_code = int_pend ? 5'd0 : exc_code;

    assign int_req   = commit_valid & int_pend;
    assign exc_flush = exc_take | eret_take;
    assign epc       = (mtc0_we && cp0_waddr == REG_EPC) ? cp0_wdata : epc_q;

    assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            REG_BADVADDR: cp0_rdata = badvaddr_q;
            REG_COUNT:    cp0_rdata = count_q;
            REG_COMPARE:  cp0_rdata = compare_q;
            REG_STATUS:   cp0_rdata = status_rd;
            REG_CAUSE:    cp0_rdata = cause_rd;
            REG_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_im   <= 8'd0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ti    <= 1'b0;
            cause_ip_hw <= 6'd0;
            cause_ip_sw <= 2'd0;
            cause_exc   <= 5'd0;
            epc_q       <= 32'd0;
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            badvaddr_q  <= 32'd0;
            tick        <= 1'b0;
        end else begin
            tick        <= ~tick;
            cause_ip_hw <= {hw_int[5] | cause_ti, hw_int[4:0]};

            if (wr_en && cp0_waddr == REG_COUNT) begin
                count_q <= cp0_wdata;
            end else if (tick) begin
                count_q <= count_q + 32'd1;
            end

            // Writing Compare acknowledges the timer even on the match cycle.
            if (wr_en && cp0_waddr == REG_COMPARE) begin
                compare_q <= cp0_wdata;
                cause_ti  <= 1'b0;
            end else if (count_q == compare_q) begin
                cause_ti  <= 1'b1;
            end

            if (wr_en && cp0_waddr == REG_STATUS) begin
                status_im <= cp0_wdata[15:8];
                status_ie <= cp0_wdata[0];
            end

            if (exc_take) begin
                status_exl <= 1'b1;
            end else if (eret_take) begin
                status_exl <= 1'b0;
            end else if (wr_en && cp0_waddr == REG_STATUS) begin
                status_exl <= cp0_wdata[1];
            end

            if (wr_en && cp0_waddr == REG_CAUSE) begin
                cause_ip_sw <= cp0_wdata[9:8];
            end

            // Nested exceptions keep the original return point.
            if (exc_take) begin
                if (!status_exl) begin
                    epc_q    <= commit_bd ? commit_pc - 32'd4 : commit_pc;
                    cause_bd <= commit_bd;
                end
                cause_exc <= taken_code;
                if (taken_code == 5'd4 || taken_code == 5'd5) begin
                    badvaddr_q <= exc_badvaddr;
                end
            end else if (wr_en && cp0_waddr == REG_EPC) begin
                epc_q <= cp0_wdata;
            end
        end
    end
endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: directed scenarios with constant expectations plus a randomized run
// checked against a register-word reference model updated on every clock.
`timescale 1ns/1ps
module tb_cp0_regs;
    logic        clk;
    logic        resetn;
    logic        mtc0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [5:0]  hw_int;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_bd;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic        eret_req;
    logic        int_req;
    logic        exc_flush;
    logic [31:0] epc;

    int n_checks = 0;
    int n_errors = 0;

    cp0_regs dut (
        .clk(clk), .resetn(resetn), .mtc0_we(mtc0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .hw_int(hw_int), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_bd(commit_bd), .exc_req(exc_req), .exc_code(exc_code),
        .exc_badvaddr(exc_badvaddr), .eret_req(eret_req), .int_req(int_req),
        .exc_flush(exc_flush), .epc(epc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each CP0 register kept as the full 32-bit word software sees.
    typedef struct packed {
        logic        tick;
        logic [31:0] count;
        logic [31:0] cmp;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] bad;
    } model_t;

    model_t m;

    function automatic logic m_pend();
        return ((m.cause[15:8] & m.status[15:8]) != 8'd0) && m.status[0] && !m.status[1];
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd8:    return m.bad;
            5'd9:    return m.count;
            5'd11:   return m.cmp;
            5'd12:   return m.status;
            5'd13:   return m.cause;
            5'd14:   return m.epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic model_t model_next();
        model_t n;
        logic pend, take, eret, wr;
        logic [4:0] code;
        n = m;
        if (!resetn) begin
            n = '0;
            n.status = 32'h0040_0000;
            return n;
        end
        pend = m_pend();
        take = commit_valid && (pend || exc_req);
        eret = commit_valid && eret_req && !take;
        wr   = mtc0_we && !take;
        n.tick = ~m.tick;
        n.cause[15] = hw_int[5] | m.cause[30];
        n.cause[14:10] = hw_int[4:0];
        if (m.count == m.cmp) n.cause[30] = 1'b1;
        n.count = m.count + (m.tick ? 32'd1 : 32'd0);
        if (wr) begin
            case (cp0_waddr)
                5'd9:  n.count = cp0_wdata;
                5'd11: begin n.cmp = cp0_wdata; n.cause[30] = 1'b0; end
                5'd12: n.status = 32'h0040_0000 | (cp0_wdata & 32'h0000_FF03);
                5'd13: n.cause[9:8] = cp0_wdata[9:8];
                5'd14: n.epc = cp0_wdata;
                default: ;
            endcase
        end
        if (eret) n.status[1] = 1'b0;
        if (take) begin
            n.status[1] = 1'b1;
            if (!m.status[1]) begin
                n.epc = commit_bd ? commit_pc - 32'd4 : commit_pc;
                n.cause[31] = commit_bd;
            end
            code = pend ? 5'd0 : exc_code;
            n.cause[6:2] = code;
            if (code == 5'd4 || code == 5'd5) n.bad = exc_badvaddr;
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next();

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mtc0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'd0; cp0_raddr = 5'd0;
        hw_int = 6'd0; commit_valid = 1'b0; commit_pc = 32'd0; commit_bd = 1'b0;
        exc_req = 1'b0; exc_code = 5'd0; exc_badvaddr = 32'd0; eret_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [7];
        logic [31:0] exp;
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        resetn = 1'b0;
        idle();
        next();
        next();
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0 || exc_flush !== 1'b0 || epc !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: int_req=%b exc_flush=%b epc=%h, expected 0 0 0", int_req, exc_flush, epc);
        end
        foreach (addrs[i]) begin
            cp0_raddr = addrs[i];
            #1;
            exp = (addrs[i] == 5'd12) ? 32'h0040_0000 : 32'd0;
            n_checks++;
            if (cp0_rdata !== exp) begin
                n_errors++;
                $display("FAIL reset_read_%0d: got %h expected %h", addrs[i], cp0_rdata, exp);
            end
        end
        next();
        resetn = 1'b1;
    endtask

    task automatic test_interrupt();
        mtc0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0401;
        next();
        mtc0_we = 1'b0; hw_int = 6'b000001; commit_valid = 1'b1; commit_pc = 32'hBFC0_0100;
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++; $display("FAIL int_cycle1: int_req=%b expected 0", int_req);
        end
        next();
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || exc_flush !== 1'b1) begin
            n_errors++; $display("FAIL int_cycle2: int_req=%b exc_flush=%b expected 1 1", int_req, exc_flush);
        end
        next();
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0 || exc_flush !== 1'b0) begin
            n_errors++; $display("FAIL int_masked: int_req=%b exc_flush=%b expected 0 0", int_req, exc_flush);
        end
        cp0_raddr = 5'd14; #1;
        n_checks++;
        if (cp0_rdata !== 32'hBFC0_0100) begin
            n_errors++; $display("FAIL int_epc: got %h expected bfc00100", cp0_rdata);
        end
        cp0_raddr = 5'd12; #1;
        n_checks++;
        if (cp0_rdata !== 32'h0040_0403) begin
            n_errors++; $display("FAIL int_status: got %h expected 00400403", cp0_rdata);
        end
        cp0_raddr = 5'd13; #1;
        n_checks++;
        if ((cp0_rdata & 32'h8000_047C) !== 32'h0000_0400) begin
            n_errors++; $display("FAIL int_cause: got %h expected IP2 set, BD=0, ExcCode=0", cp0_rdata);
        end
        next();
        hw_int = 6'd0; eret_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (exc_flush !== 1'b1 || int_req !== 1'b0) begin
            n_errors++; $display("FAIL int_eret: exc_flush=%b int_req=%b expected 1 0", exc_flush, int_req);
        end
        next();
        idle();
    endtask

    task automatic test_exception();
        commit_valid = 1'b1; exc_req = 1'b1; exc_code = 5'd4; commit_bd = 1'b1;
        commit_pc = 32'h8000_0014; exc_badvaddr = 32'h0000_1235;
        @(negedge clk);
        n_checks++;
        if (exc_flush !== 1'b1 || int_req !== 1'b0) begin
            n_errors++; $display("FAIL exc_flush: exc_flush=%b int_req=%b expected 1 0", exc_flush, int_req);
        end
        next();
        idle();
        @(negedge clk);
        cp0_raddr = 5'd14; #1;
        n_checks++;
        if (cp0_rdata !== 32'h8000_0010) begin
            n_errors++; $display("FAIL exc_epc_bd: got %h expected 80000010", cp0_rdata);
        end
        cp0_raddr = 5'd13; #1;
        n_checks++;
        if ((cp0_rdata & 32'h8000_007C) !== 32'h8000_0010) begin
            n_errors++; $display("FAIL exc_cause: got %h expected BD=1 ExcCode=4", cp0_rdata);
        end
        cp0_raddr = 5'd8; #1;
        n_checks++;
        if (cp0_rdata !== 32'h0000_1235) begin
            n_errors++; $display("FAIL exc_badvaddr: got %h expected 00001235", cp0_rdata);
        end
        next();
        commit_valid = 1'b1; exc_req = 1'b1; exc_code = 5'd5; commit_pc = 32'h0000_0020;
        exc_badvaddr = 32'h0000_5678;
        next();
        idle();
        @(negedge clk);
        cp0_raddr = 5'd14; #1;
        n_checks++;
        if (cp0_rdata !== 32'h8000_0010) begin
            n_errors++; $display("FAIL nested_epc: got %h expected 80000010", cp0_rdata);
        end
        cp0_raddr = 5'd13; #1;
        n_checks++;
        if ((cp0_rdata & 32'h8000_007C) !== 32'h8000_0014) begin
            n_errors++; $display("FAIL nested_cause: got %h expected BD=1 ExcCode=5", cp0_rdata);
        end
        cp0_raddr = 5'd8; #1;
        n_checks++;
        if (cp0_rdata !== 32'h0000_5678) begin
            n_errors++; $display("FAIL nested_badvaddr: got %h expected 00005678", cp0_rdata);
        end
        next();
        commit_valid = 1'b1; exc_req = 1'b1; exc_code = 5'd10; exc_badvaddr = 32'h0000_9999;
        next();
        idle();
        mtc0_we = 1'b1; cp0_waddr = 5'd8; cp0_wdata = 32'h0000_FFFF;
        next();
        idle();
        @(negedge clk);
        cp0_raddr = 5'd8; #1;
        n_checks++;
        if (cp0_rdata !== 32'h0000_5678) begin
            n_errors++; $display("FAIL badvaddr_hold: got %h expected 00005678", cp0_rdata);
        end
        cp0_raddr = 5'd13; #1;
        n_checks++;
        if ((cp0_rdata & 32'h0000_007C) !== 32'h0000_0028) begin
            n_errors++; $display("FAIL ri_code: got %h expected ExcCode=10", cp0_rdata);
        end
        next();
        commit_valid = 1'b1; eret_req = 1'b1;
        next();
        idle();
    endtask

    task automatic test_timer();
        int  waited = 0;
        logic got = 1'b0;
        mtc0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_8001;
        next();
        cp0_waddr = 5'd11; cp0_wdata = 32'd10;
        next();
        cp0_waddr = 5'd9; cp0_wdata = 32'd0;
        next();
        idle();
        commit_valid = 1'b1; commit_pc = 32'h0000_0100;
        while (!got && waited < 60) begin
            @(negedge clk);
            n_checks++;
            if (int_req !== (commit_valid & m_pend())) begin
                n_errors++; $display("FAIL timer_int_req: got %b expected %b at wait %0d", int_req, commit_valid & m_pend(), waited);
            end
            if (int_req === 1'b1) got = 1'b1;
            else begin
                next();
                waited++;
            end
        end
        n_checks++;
        if (!got || waited < 18) begin
            n_errors++; $display("FAIL timer_rise: got=%b after %0d cycles, expected rise within 18..60", got, waited);
        end
        cp0_raddr = 5'd13; #1;
        n_checks++;
        if (cp0_rdata[30] !== 1'b1) begin
            n_errors++; $display("FAIL timer_ti_set: TI=%b expected 1", cp0_rdata[30]);
        end
        next();
        idle();
        mtc0_we = 1'b1; cp0_waddr = 5'd11; cp0_wdata = 32'd10;
        next();
        idle();
        @(negedge clk);
        cp0_raddr = 5'd13; #1;
        n_checks++;
        if (cp0_rdata[30] !== 1'b0) begin
            n_errors++; $display("FAIL timer_ti_clear: TI=%b expected 0", cp0_rdata[30]);
        end
        next();
        commit_valid = 1'b1; eret_req = 1'b1;
        next();
        idle();
    endtask

    task automatic test_priority();
        mtc0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0401; hw_int = 6'b000001;
        next();
        mtc0_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0 || exc_flush !== 1'b0) begin
            n_errors++; $display("FAIL bubble: int_req=%b exc_flush=%b expected 0 0", int_req, exc_flush);
        end
        next();
        commit_valid = 1'b1; exc_req = 1'b1; exc_code = 5'd4; exc_badvaddr = 32'h0000_DEAD;
        commit_pc = 32'h0000_0300; mtc0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'd0;
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || exc_flush !== 1'b1) begin
            n_errors++; $display("FAIL prio_take: int_req=%b exc_flush=%b expected 1 1", int_req, exc_flush);
        end
        next();
        idle();
        @(negedge clk);
        cp0_raddr = 5'd12; #1;
        n_checks++;
        if (cp0_rdata !== 32'h0040_0403) begin
            n_errors++; $display("FAIL prio_status: got %h expected 00400403", cp0_rdata);
        end
        cp0_raddr = 5'd13; #1;
        n_checks++;
        if ((cp0_rdata & 32'h0000_007C) !== 32'd0) begin
            n_errors++; $display("FAIL prio_code: got %h expected ExcCode=0", cp0_rdata);
        end
        cp0_raddr = 5'd8; #1;
        n_checks++;
        if (cp0_rdata !== 32'h0000_5678) begin
            n_errors++; $display("FAIL prio_badvaddr: got %h expected 00005678", cp0_rdata);
        end
        next();
        commit_valid = 1'b1; eret_req = 1'b1; mtc0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h0000_0400;
        @(negedge clk);
        n_checks++;
        if (epc !== 32'h0000_0400 || exc_flush !== 1'b1 || int_req !== 1'b0) begin
            n_errors++; $display("FAIL eret_fwd: epc=%h flush=%b int=%b expected 00000400 1 0", epc, exc_flush, int_req);
        end
        next();
        idle();
        @(negedge clk);
        cp0_raddr = 5'd12; #1;
        n_checks++;
        if (cp0_rdata !== 32'h0040_0401) begin
            n_errors++; $display("FAIL eret_status: got %h expected 00400401", cp0_rdata);
        end
        cp0_raddr = 5'd14; #1;
        n_checks++;
        if (cp0_rdata !== 32'h0000_0400 || epc !== 32'h0000_0400) begin
            n_errors++; $display("FAIL eret_epc: rdata=%h epc=%h expected 00000400", cp0_rdata, epc);
        end
        next();
    endtask

    task automatic test_random();
        logic [4:0] regs [7];
        logic [31:0] exp_epc;
        regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        for (int i = 0; i < 2000; i++) begin
            resetn       = ($urandom_range(0, 63) != 0);
            mtc0_we      = ($urandom_range(0, 3) == 0);
            cp0_waddr    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 6)];
            cp0_wdata    = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            cp0_raddr    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 6)];
            hw_int       = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
            commit_valid = ($urandom_range(0, 1) == 0);
            commit_pc    = $urandom & 32'hFFFF_FFFC;
            commit_bd    = ($urandom_range(0, 3) == 0);
            exc_req      = ($urandom_range(0, 7) == 0);
            exc_code     = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            exc_badvaddr = $urandom;
            eret_req     = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            exp_epc = (mtc0_we && cp0_waddr == 5'd14) ? cp0_wdata : m.epc;
            n_checks++;
            if (int_req !== (commit_valid & m_pend())) begin
                n_errors++; $display("FAIL rand_int_req[%0d]: got %b expected %b", i, int_req, commit_valid & m_pend());
            end
            n_checks++;
            if (exc_flush !== (commit_valid & (m_pend() | exc_req | eret_req))) begin
                n_errors++; $display("FAIL rand_flush[%0d]: got %b expected %b", i, exc_flush, commit_valid & (m_pend() | exc_req | eret_req));
            end
            n_checks++;
            if (epc !== exp_epc) begin
                n_errors++; $display("FAIL rand_epc[%0d]: got %h expected %h", i, epc, exp_epc);
            end
            n_checks++;
            if (cp0_rdata !== m_rd(cp0_raddr)) begin
                n_errors++; $display("FAIL rand_rdata[%0d] reg %0d: got %h expected %h", i, cp0_raddr, cp0_rdata, m_rd(cp0_raddr));
            end
            next();
        end
        resetn = 1'b1;
        idle();
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        test_reset();
        test_interrupt();
        test_exception();
        test_timer();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
